// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates cpu (MEM stage) vs aux requester onto one data memory port with starvation-forced aux grants; ports: clk/reset, cpu_* request/stall/load return, aux_* request/grant/load return, mem_* memory port
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr_en,
  input  logic        cpu_rd_en,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wr_data,
  output logic        cpu_stall,
  output logic [63:0] cpu_rd_data,
  output logic        cpu_rd_valid,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [63:0] aux_addr,
  input  logic [63:0] aux_wr_data,
  output logic        aux_gnt,
  output logic [63:0] aux_rd_data,
  output logic        aux_rd_valid,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [63:0] mem_rd_data
);
  typedef enum logic [1:0] {S_IDLE, S_CPU, S_AUX} state_t;
  state_t state;
  logic [7:0] starve_cnt;
  logic rd_issued, cpu_act, forced, cpu_gnt;
  always_comb begin
    cpu_act = !reset && (cpu_wr_en || cpu_rd_en);
    forced = !reset && aux_req && starve_cnt == 8'(STARVE_LIMIT);
    cpu_gnt = cpu_act && !forced;
    aux_gnt = !reset && aux_req && (!cpu_act || forced);
    cpu_stall = cpu_act && forced;
    mem_wr_en = cpu_gnt ? cpu_wr_en : aux_gnt && aux_we;
    mem_rd_en = cpu_gnt ? !cpu_wr_en && cpu_rd_en : aux_gnt && !aux_we;
    mem_addr = cpu_gnt ? cpu_addr : aux_gnt ? aux_addr : '0;
    mem_wr_data = cpu_gnt ? cpu_wr_data : aux_gnt ? aux_wr_data : '0;
    // last-cycle owner plus a registered read flag together form the read-owner
    cpu_rd_valid = !reset && rd_issued && state == S_CPU;
    aux_rd_valid = !reset && rd_issued && state == S_AUX;
    cpu_rd_data = cpu_rd_valid ? mem_rd_data : '0;
    aux_rd_data = aux_rd_valid ? mem_rd_data : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      starve_cnt <= '0;
      rd_issued <= 1'b0;
    end else begin
      state <= cpu_gnt ? S_CPU : aux_gnt ? S_AUX : S_IDLE;
      rd_issued <= mem_rd_en;
      starve_cnt <= (!aux_req || aux_gnt) ? '0 :
                    starve_cnt == 8'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 8'd1;
    end
endmodule
